uart_tx_arbiter: RTL and testbench

//  Shares the single UART transmitter between NUM_REQ byte sources using round-robin arbitration.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_rr_arbiter.sv | 31 +++
 rtl/uart_tx_arbiter.sv | 116 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
package uart_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  // Ceiling log2, never less than 1 so index vectors always have a bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin select: the search starts one past ptr and wraps.
module uart_rr_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int IDX_W  = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any
);

  always_comb begin
    logic [IDX_W-1:0] cand;
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    cand      = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IDX_W'((int'(ptr) + i) % NUM_REQ);
      if (!any && req[cand]) begin
        grant[cand] = 1'b1;
        grant_idx   = cand;
        any         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among NUM_REQ byte sources.
// Define UART_ARB_PKT_LOCK_EN to hold the grant on one requester until a req_last byte.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int BUSY_WAIT = 8,
  localparam int IDX_W    = clog2(NUM_REQ),
  localparam int CNT_W    = clog2(BUSY_WAIT)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [BYTE_W*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [BYTE_W-1:0]         TxData,
  output logic                      transmit,
  input  logic                      busy,
  output logic [IDX_W-1:0]          grant_id,
  output logic                      active,
  output logic                      tx_err
);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr;
  logic [CNT_W-1:0]   cnt_q;
  logic [NUM_REQ-1:0] elig, arb_grant;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any, accept, ptr_adv;

`ifdef UART_ARB_PKT_LOCK_EN
  logic lock_q;

  // While a packet is open only its owner may be granted, and the pointer stays put.
  assign elig    = lock_q ? (req_valid & ({{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id)) : req_valid;
  assign ptr_adv = !lock_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      lock_q <= 1'b0;
    else if (accept) lock_q <= !req_last[arb_idx];
    else if (tx_err) lock_q <= 1'b0;
  end
`else
  logic unused_req_last;

  assign elig            = req_valid;
  assign ptr_adv         = 1'b1;
  assign unused_req_last = ^req_last;
`endif

  uart_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req       (elig),
    .ptr       (rr_ptr),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any       (arb_any)
  );

  // Ready is gated by reset so nothing is handshaken while the block is held in reset.
  assign accept    = reset && (state_q == IDLE) && !busy && arb_any;
  assign req_ready = accept ? arb_grant : '0;
  assign active    = (state_q != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    transmit = 1'b0;
    tx_err   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) state_d = LOAD;
      end
      LOAD: begin
        transmit = 1'b1;
        state_d  = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (busy) begin
          state_d = WAIT_DONE;
        end else if (cnt_q == CNT_W'(BUSY_WAIT - 1)) begin
          tx_err  = 1'b1;
          state_d = IDLE;
        end else begin
          transmit = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      TxData   <= '0;
      grant_id <= '0;
      rr_ptr   <= IDX_W'(NUM_REQ - 1);
      cnt_q    <= '0;
    end else begin
      if (accept) begin
        TxData   <= req_data[arb_idx*BYTE_W +: BYTE_W];
        grant_id <= arb_idx;
      end
      if (state_q == LOAD)           cnt_q <= '0;
      else if (state_q == WAIT_BUSY) cnt_q <= cnt_q + CNT_W'(1);
      if (state_q == WAIT_DONE && !busy && ptr_adv) rr_ptr <= grant_id;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter with a simple UART busy model.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int BUSY_WAIT = 8;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NUM_REQ-1:0]   req_valid, req_last, req_ready;
  logic [8*NUM_REQ-1:0] req_data;
  logic [7:0]           TxData;
  logic                 transmit, busy, active, tx_err;
  logic [1:0]           grant_id;

  int tests_run    = 0;
  int tests_failed = 0;
  bit model_en     = 1'b0;
  bit ext_busy     = 1'b0;
  int rise_delay   = 1;
  int busy_len     = 1;
  int tx_rises     = 0;
  int ready_cycles = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .BUSY_WAIT(BUSY_WAIT)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .TxData    (TxData),
    .transmit  (transmit),
    .busy      (busy),
    .grant_id  (grant_id),
    .active    (active),
    .tx_err    (tx_err)
  );

  // UART model: busy rises rise_delay cycles after transmit is seen and stays up busy_len cycles.
  initial begin : busy_model
    bit in_frame;
    int tick;
    in_frame = 1'b0;
    tick     = 0;
    busy     = 1'b0;
    forever begin
      @(negedge clk); #1;
      if (!model_en) begin
        in_frame = 1'b0;
        busy     = ext_busy;
      end else begin
        if (!in_frame && transmit) begin
          in_frame = 1'b1;
          tick     = 0;
        end
        if (in_frame) begin
          tick++;
          busy = (tick > rise_delay) && (tick <= rise_delay + busy_len);
          if (tick > rise_delay + busy_len) in_frame = 1'b0;
        end else begin
          busy = 1'b0;
        end
      end
    end
  end

  initial begin : monitor
    logic tx_prev;
    tx_prev = 1'b0;
    forever begin
      @(negedge clk); #2;
      if (transmit && !tx_prev) tx_rises++;
      tx_prev = transmit;
      if (req_ready != '0) ready_cycles++;
    end
  end

  // Called at a falling edge; returns 2 time units after the falling edge of the grant cycle.
  task automatic wait_ready(input int max_cycles, output bit ok, output int idle_gaps);
    ok        = 1'b0;
    idle_gaps = 0;
    for (int i = 0; i < max_cycles; i++) begin
      #2;
      if (req_ready != '0) begin
        ok = 1'b1;
        break;
      end
      if (!active) idle_gaps++;
      @(negedge clk);
    end
  endtask

  task automatic wait_idle(input int max_cycles, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk); #2;
      if (!active && !busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset    = 1'b0;
    model_en = 1'b0;
    ext_busy = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    req_valid = '1;
    req_last  = '1;
    req_data  = 32'h1111_1111;
    repeat (3) @(negedge clk);
    #2;
    tests_run++; if (req_ready !== 4'b0000) begin tests_failed++; $display("[TB] FAIL reset_req_ready got %b want 0000", req_ready); end
    tests_run++; if (TxData !== 8'h00) begin tests_failed++; $display("[TB] FAIL reset_txdata got %h want 00", TxData); end
    tests_run++; if (transmit !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_transmit got %b want 0", transmit); end
    tests_run++; if (grant_id !== 2'd0) begin tests_failed++; $display("[TB] FAIL reset_grant_id got %0d want 0", grant_id); end
    tests_run++; if (active !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_active got %b want 0", active); end
    tests_run++; if (tx_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_tx_err got %b want 0", tx_err); end
    @(negedge clk);
    req_valid = '0;
    reset     = 1'b1;
  endtask

  task automatic test_single(input int d, input int len);
    bit ok;
    int gaps;
    model_en     = 1'b1;
    rise_delay   = d;
    busy_len     = len;
    @(negedge clk);
    tx_rises     = 0;
    ready_cycles = 0;
    req_data[7:0] = 8'hA3;
    req_valid     = 4'b0001;
    wait_ready(20, ok, gaps);
    tests_run++; if (!ok) begin tests_failed++; $display("[TB] FAIL single_grant_timeout got none want grant (len %0d)", len); end
    tests_run++; if (req_ready !== 4'b0001) begin tests_failed++; $display("[TB] FAIL single_ready got %b want 0001", req_ready); end
    @(negedge clk);
    req_valid = '0;
    #2;
    tests_run++; if (TxData !== 8'hA3) begin tests_failed++; $display("[TB] FAIL single_txdata got %h want a3", TxData); end
    tests_run++; if (transmit !== 1'b1) begin tests_failed++; $display("[TB] FAIL single_latency transmit got %b want 1", transmit); end
    wait_idle(d + len + 30, ok);
    tests_run++; if (!ok) begin tests_failed++; $display("[TB] FAIL single_idle_timeout got busy want idle (len %0d)", len); end
    tests_run++; if (tx_rises !== 1) begin tests_failed++; $display("[TB] FAIL single_strobes got %0d want 1", tx_rises); end
    tests_run++; if (ready_cycles !== 1) begin tests_failed++; $display("[TB] FAIL single_ready_cycles got %0d want 1", ready_cycles); end
    tests_run++; if (TxData !== 8'hA3) begin tests_failed++; $display("[TB] FAIL single_txdata_hold got %h want a3", TxData); end
  endtask

  task automatic test_round_robin();
    bit ok;
    int gaps;
    logic [3:0] exp_ready;
    logic [7:0] exp_data;
    pulse_reset();
    model_en   = 1'b1;
    rise_delay = 1;
    busy_len   = 4;
    req_data   = {8'h13, 8'h12, 8'h11, 8'h10};
    req_valid  = 4'b1111;
    for (int f = 0; f < 8; f++) begin
      exp_ready = 4'b0001 << (f % 4);
      exp_data  = 8'h10 + 8'(f % 4);
      wait_ready(30, ok, gaps);
      tests_run++; if (!ok) begin tests_failed++; $display("[TB] FAIL rr_timeout frame %0d got none want grant", f); end
      tests_run++; if (req_ready !== exp_ready) begin tests_failed++; $display("[TB] FAIL rr_order frame %0d got %b want %b", f, req_ready, exp_ready); end
      if (f > 0) begin
        tests_run++; if (gaps !== 0) begin tests_failed++; $display("[TB] FAIL rr_active_gap frame %0d got %0d idle cycles want 0", f, gaps); end
      end
      @(negedge clk);
      if (f == 7) req_valid = '0;
      #2;
      tests_run++; if (grant_id !== 2'(f % 4)) begin tests_failed++; $display("[TB] FAIL rr_grant_id frame %0d got %0d want %0d", f, grant_id, f % 4); end
      tests_run++; if (TxData !== exp_data) begin tests_failed++; $display("[TB] FAIL rr_txdata frame %0d got %h want %h", f, TxData, exp_data); end
      tests_run++; if (transmit !== 1'b1) begin tests_failed++; $display("[TB] FAIL rr_transmit frame %0d got %b want 1", f, transmit); end
      @(negedge clk);
    end
    wait_idle(30, ok);
    tests_run++; if (!ok) begin tests_failed++; $display("[TB] FAIL rr_idle_timeout got busy want idle"); end
  endtask

  task automatic test_busy_timeout();
    bit ok;
    int gaps, hi, errs, err_at, regrant_at;
    model_en = 1'b0;
    ext_busy = 1'b0;
    @(negedge clk);
    req_data[7:0] = 8'h55;
    req_valid     = 4'b0001;
    wait_ready(20, ok, gaps);
    tests_run++; if (!ok) begin tests_failed++; $display("[TB] FAIL timeout_grant got none want grant"); end
    hi = 0; errs = 0; err_at = -1; regrant_at = -1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk); #2;
      if (transmit) hi++;
      if (tx_err) begin
        errs++;
        err_at = c;
      end
      if (req_ready != '0 && regrant_at < 0) regrant_at = c;
    end
    tests_run++; if (hi !== BUSY_WAIT) begin tests_failed++; $display("[TB] FAIL timeout_transmit_len got %0d want %0d", hi, BUSY_WAIT); end
    tests_run++; if (errs !== 1) begin tests_failed++; $display("[TB] FAIL timeout_err_pulses got %0d want 1", errs); end
    tests_run++; if (err_at !== 9) begin tests_failed++; $display("[TB] FAIL timeout_err_cycle got %0d want 9", err_at); end
    tests_run++; if (regrant_at !== 10) begin tests_failed++; $display("[TB] FAIL timeout_regrant_cycle got %0d want 10", regrant_at); end
    @(negedge clk);
    req_valid = '0;
    wait_idle(30, ok);
    tests_run++; if (!ok) begin tests_failed++; $display("[TB] FAIL timeout_idle got busy want idle"); end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    int gaps;
    model_en   = 1'b1;
    rise_delay = 1;
    busy_len   = 20;
    @(negedge clk);
    req_data[23:16] = 8'h77;
    req_valid       = 4'b0100;
    wait_ready(20, ok, gaps);
    tests_run++; if (!ok) begin tests_failed++; $display("[TB] FAIL midreset_grant got none want grant"); end
    @(negedge clk);
    req_valid = 4'b0110;
    repeat (3) @(negedge clk);
    #2;
    tests_run++; if (active !== 1'b1 || grant_id !== 2'd2) begin tests_failed++; $display("[TB] FAIL midreset_pre got active %b id %0d want 1 2", active, grant_id); end
    @(negedge clk);
    reset    = 1'b0;
    model_en = 1'b0;
    ext_busy = 1'b0;
    #2;
    tests_run++; if (transmit !== 1'b0) begin tests_failed++; $display("[TB] FAIL midreset_transmit got %b want 0", transmit); end
    tests_run++; if (active !== 1'b0) begin tests_failed++; $display("[TB] FAIL midreset_active got %b want 0", active); end
    tests_run++; if (grant_id !== 2'd0) begin tests_failed++; $display("[TB] FAIL midreset_grant_id got %0d want 0", grant_id); end
    tests_run++; if (TxData !== 8'h00) begin tests_failed++; $display("[TB] FAIL midreset_txdata got %h want 00", TxData); end
    tests_run++; if (req_ready !== 4'b0000) begin tests_failed++; $display("[TB] FAIL midreset_ready got %b want 0000", req_ready); end
    repeat (2) @(negedge clk);
    reset      = 1'b1;
    model_en   = 1'b1;
    rise_delay = 1;
    busy_len   = 2;
    wait_ready(20, ok, gaps);
    tests_run++; if (req_ready !== 4'b0010) begin tests_failed++; $display("[TB] FAIL midreset_lowest got %b want 0010", req_ready); end
    @(negedge clk);
    req_valid = '0;
    #2;
    tests_run++; if (grant_id !== 2'd1) begin tests_failed++; $display("[TB] FAIL midreset_new_id got %0d want 1", grant_id); end
    wait_idle(30, ok);
    tests_run++; if (!ok) begin tests_failed++; $display("[TB] FAIL midreset_idle got busy want idle"); end
  endtask

  task automatic test_packet();
    bit ok;
    int gaps, sent1, got;
    int exp_order[4];
`ifdef UART_ARB_PKT_LOCK_EN
    exp_order = '{1, 1, 1, 2};
`else
    exp_order = '{1, 2, 1, 2};
`endif
    pulse_reset();
    model_en        = 1'b1;
    rise_delay      = 1;
    busy_len        = 2;
    sent1           = 0;
    req_data[15:8]  = 8'hB0;
    req_data[23:16] = 8'hC0;
    req_last        = 4'b0100;
    req_valid       = 4'b0110;
    for (int g = 0; g < 4; g++) begin
      wait_ready(30, ok, gaps);
      if (req_ready === 4'b0010)      got = 1;
      else if (req_ready === 4'b0100) got = 2;
      else                            got = -1;
      tests_run++; if (got !== exp_order[g]) begin tests_failed++; $display("[TB] FAIL packet_order grant %0d got %0d want %0d", g, got, exp_order[g]); end
      @(negedge clk);
      if (got == 1) begin
        sent1++;
        req_data[15:8] = 8'hB0 + 8'(sent1);
        req_last[1]    = (sent1 == 2);
        if (sent1 == 3) req_valid[1] = 1'b0;
      end
      if (g == 3) req_valid = '0;
      @(negedge clk);
    end
    wait_idle(30, ok);
    tests_run++; if (!ok) begin tests_failed++; $display("[TB] FAIL packet_idle got busy want idle"); end
    req_last = '1;
  endtask

  task automatic test_external_busy();
    bit ok;
    int gaps, early;
    model_en = 1'b0;
    ext_busy = 1'b1;
    @(negedge clk);
    req_data[31:24] = 8'h9C;
    req_valid       = 4'b1000;
    early           = 0;
    for (int i = 0; i < 6; i++) begin
      #2;
      if (req_ready != '0) early++;
      @(negedge clk);
    end
    tests_run++; if (early !== 0) begin tests_failed++; $display("[TB] FAIL extbusy_early_ready got %0d cycles want 0", early); end
    ext_busy = 1'b0;
    wait_ready(10, ok, gaps);
    tests_run++; if (req_ready !== 4'b1000) begin tests_failed++; $display("[TB] FAIL extbusy_ready got %b want 1000", req_ready); end
    tests_run++; if (gaps !== 0) begin tests_failed++; $display("[TB] FAIL extbusy_first_cycle got %0d wait cycles want 0", gaps); end
    @(negedge clk);
    req_valid  = '0;
    model_en   = 1'b1;
    rise_delay = 1;
    busy_len   = 2;
    #2;
    tests_run++; if (TxData !== 8'h9C) begin tests_failed++; $display("[TB] FAIL extbusy_txdata got %h want 9c", TxData); end
    wait_idle(30, ok);
    tests_run++; if (!ok) begin tests_failed++; $display("[TB] FAIL extbusy_idle got busy want idle"); end
  endtask

  initial begin
    reset     = 1'b0;
    req_valid = '0;
    req_last  = '1;
    req_data  = '0;
    test_reset();
    test_single(1, 1);
    test_single(3, 170);
    test_round_robin();
    test_busy_timeout();
    test_reset_mid_frame();
    test_packet();
    test_external_busy();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
